rng_share_arbiter: RTL and testbench
====================================

RNG_SHARE_ARBITER -- requirements
Module: rng_share_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of randomness requesters (2..8).
REQ-002 Parameter DISCARD, default 4: PRNG words discarded after reset or flush before serving (1..15).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 rng_in  input  32  PRNG word from the xorshift generator.
REQ-006 rng_vld  input  1  rng_in is a new, never-delivered word this cycle.
REQ-007 flush  input  1  single-cycle pulse: discard buffered randomness, re-enter warm-up (used on PRNG reseed).
REQ-008 req  input  NREQ  per-requester request, held high until granted.
REQ-009 gnt  output  NREQ  registered one-hot grant, one cycle wide.
REQ-010 rnd_out  output  32  registered randomness word, valid only when rnd_vld=1.
REQ-011 rnd_vld  output  1  registered; equals |gnt.
REQ-012 ready  output  1  registered; high in SERVE state.
REQ-013 drop_cnt  output  16  count of PRNG words overwritten/discarded while SERVE, saturating at 16'hFFFF.

Function
REQ-014 FSM states: WARMUP, SERVE; transitions only as specified below.
REQ-015 WARMUP: each rng_vld=1 cycle increments a 4-bit discard counter; words are not buffered; when counter reaches DISCARD, next state SERVE with counter cleared.
REQ-016 SERVE: a single 32-bit buffer with flag buf_full; buffer loads rng_in when rng_vld=1 and (buf_full=0 or buffer consumed this cycle).
REQ-017 SERVE, rng_vld=1, buf_full=1 and no consumption: buffer keeps old word, new word dropped, drop_cnt increments.
REQ-018 Arbitration in cycle t: if SERVE, buf_full=1, |req=1 and flush=0, winner = first set req bit scanning from pointer ptr upward with wrap NREQ-1 -> 0.
REQ-019 At t+1: gnt has only winner bit set, rnd_out = buffer word of cycle t, rnd_vld=1; buffer counts as consumed in cycle t.
REQ-020 ptr (reset 0) updates to (winner+1) mod NREQ on each grant; unchanged otherwise.
REQ-021 At most one grant per cycle; a given buffered word is delivered at most once (no word ever reaches two requesters).
REQ-022 Consume and refill in same cycle: buffer takes rng_in, buf_full stays 1, no drop counted.
REQ-023 No grant when buf_full=0, even if rng_vld=1 same cycle (word must be registered first); grant latency from word arrival = 2 cycles minimum.
REQ-024 flush=1 in any state: next state WARMUP, buf_full cleared, discard counter cleared, no grant issued at t+1; ptr and drop_cnt retained.
REQ-025 flush has priority over rng_vld, arbitration and WARMUP->SERVE transition in the same cycle.
REQ-026 When not granting, gnt=0, rnd_vld=0 and rnd_out=32'h0 (no stale randomness on the bus).
REQ-027 ready=1 iff state is SERVE (registered, reflects current state).

Reset
REQ-028 rst=1 at rising edge: state WARMUP, discard counter 0, buf_full 0, buffer 32'h0, ptr 0, gnt 0, rnd_out 32'h0, rnd_vld 0, ready 0, drop_cnt 0.
REQ-029 rst overrides flush, rng_vld and req; reset mid-grant cancels any pending grant for the next cycle.

Verification
REQ-030 Warm-up: reset, rng_vld=1 every cycle with words 1,2,3,4,5, req=4'b0001 -> words 1-4 discarded, ready=1 after 4th, word 5 delivered with gnt=4'b0001, rnd_out=5.
REQ-031 Round robin: SERVE, req=4'b1111 held, fresh word every cycle -> gnt sequence 0001,0010,0100,1000,0001, each rnd_out distinct and equal to input order.
REQ-032 Drop: SERVE, req=0, rng_vld=1 for 10 cycles -> buffer holds first word, drop_cnt=9; then req=4'b0100 -> gnt=4'b0100, rnd_out=first word.
REQ-033 Flush: SERVE with buf_full=1, flush and req=4'b0010 same cycle -> no grant next cycle, ready=0, DISCARD new words required before next grant.
REQ-034 Starvation of source: req=4'b0011, rng_vld=0 -> gnt stays 0, rnd_out=0; single word arrives -> exactly one grant, to requester at ptr.
REQ-035 Reset mid-operation: rst during cycle with winner chosen -> next cycle gnt=0, all outputs at REQ-028 values.

Source files
------------

// File: rtl/rng_share_arbiter.sv
// rng_share_arbiter: shares one buffered PRNG word among NREQ requesters, round-robin,
// after discarding DISCARD words of warm-up following reset or flush.
module rng_share_arbiter #(
   parameter int NREQ    = 4,
   parameter int DISCARD = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [31:0]     rng_in,
   input  logic            rng_vld,
   input  logic            flush,
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] gnt,
   output logic [31:0]     rnd_out,
   output logic            rnd_vld,
   output logic            ready,
   output logic [15:0]     drop_cnt
);
   localparam int PW = $clog2(NREQ);
   typedef enum logic {WARMUP, SERVE} state_t;
   state_t state, state_n;
   logic [3:0] dcnt, dcnt_n;
   logic [31:0] buf_q;
   logic buf_full, win, load, drop, warm_hit;
   logic [PW-1:0] ptr, win_idx;
   logic [NREQ-1:0] hi, pick;
   always_comb begin
      hi = req & ~((NREQ'(1) << ptr) - NREQ'(1));
      pick = (|hi) ? hi : req;
      win_idx = '0;
      for (int i = NREQ - 1; i >= 0; i--) if (pick[i]) win_idx = PW'(i);
      win = state == SERVE && buf_full && |req && !flush;
      load = state == SERVE && !flush && rng_vld && (!buf_full || win);
      drop = state == SERVE && !flush && rng_vld && buf_full && !win;
      warm_hit = state == WARMUP && !flush && rng_vld && dcnt == 4'(DISCARD - 1);
      state_n = flush ? WARMUP : warm_hit ? SERVE : state;
      dcnt_n = (flush || warm_hit) ? 4'd0 : (state == WARMUP && rng_vld) ? dcnt + 4'd1 : dcnt;
   end
   always_ff @(posedge clk) begin
      if (rst) state <= WARMUP;
      else state <= state_n;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         dcnt <= '0;
         buf_q <= '0;
         buf_full <= 1'b0;
         ptr <= '0;
         drop_cnt <= '0;
         gnt <= '0;
         rnd_out <= '0;
         rnd_vld <= 1'b0;
      end else begin
         dcnt <= dcnt_n;
         if (load) buf_q <= rng_in;
         buf_full <= flush ? 1'b0 : load ? 1'b1 : win ? 1'b0 : buf_full;
         if (win) ptr <= (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
         if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
         gnt <= win ? NREQ'(1) << win_idx : '0;
         rnd_out <= win ? buf_q : '0;
         rnd_vld <= win;
      end
   end
   assign ready = state == SERVE;
endmodule

// File: tb/tb_rng_share_arbiter.sv
// tb_rng_share_arbiter: directed scenarios with literal expectations plus a
// cycle-level behavioural model compared on every falling edge.
module tb_rng_share_arbiter;
   localparam int N = 4;
   localparam int DISC = 4;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [31:0] rng_in = '0;
   logic rng_vld = 1'b0;
   logic flush = 1'b0;
   logic [N-1:0] req = '0;
   logic [N-1:0] gnt;
   logic [31:0] rnd_out;
   logic rnd_vld, ready;
   logic [15:0] drop_cnt;
   int checks = 0;
   int failures = 0;

   rng_share_arbiter #(.NREQ(N), .DISCARD(DISC)) dut (
      .clk(clk), .rst(rst), .rng_in(rng_in), .rng_vld(rng_vld), .flush(flush),
      .req(req), .gnt(gnt), .rnd_out(rnd_out), .rnd_vld(rnd_vld), .ready(ready),
      .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Model: serving flag, warm-up count, one-word buffer, pointer, drop tally.
   bit m_on = 0;
   bit serve, full;
   int cnt, ptr, drop;
   logic [31:0] bufw, e_rnd;
   logic [N-1:0] e_gnt;
   always @(posedge clk) begin
      if (rst) begin
         m_on = 1; serve = 0; full = 0; cnt = 0; ptr = 0; drop = 0;
         bufw = '0; e_rnd = '0; e_gnt = '0;
      end else if (m_on) begin
         bit win, found;
         int w;
         win = serve && full && req != '0 && !flush;
         found = 0;
         w = 0;
         for (int i = 0; i < N; i++) begin
            int j;
            j = (ptr + i) % N;
            if (!found && ((req >> j) & 4'd1) != 4'd0) begin found = 1; w = j; end
         end
         e_gnt = win ? (4'b0001 << w) : 4'b0000;
         e_rnd = win ? bufw : 32'h0;
         if (flush) begin
            serve = 0; cnt = 0; full = 0;
         end else if (!serve) begin
            if (rng_vld) cnt++;
            if (cnt == DISC) begin serve = 1; cnt = 0; end
         end else if (rng_vld && (!full || win)) begin
            bufw = rng_in; full = 1;
         end else if (rng_vld) begin
            if (drop < 65535) drop++;
         end else if (win) full = 0;
         if (win) ptr = (w + 1) % N;
      end
   end

   always @(negedge clk) if (m_on) begin
      chk("m_gnt", 32'(gnt), 32'(e_gnt));
      chk("m_rnd_out", rnd_out, e_rnd);
      chk("m_rnd_vld", 32'(rnd_vld), 32'(|e_gnt));
      chk("m_ready", 32'(ready), 32'(serve));
      chk("m_drop_cnt", 32'(drop_cnt), 32'(drop));
   end

   task automatic step(input logic f, input logic v, input logic [31:0] w, input logic [N-1:0] r);
      flush = f; rng_vld = v; rng_in = w; req = r;
      @(posedge clk); #1;
   endtask

   initial begin
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("reset_gnt", 32'(gnt), 0);
      chk("reset_ready", 32'(ready), 0);
      // warm-up: words 1-4 discarded, word 5 served
      for (int k = 1; k <= 4; k++) step(0, 1, k, 4'b0001);
      chk("warm_ready", 32'(ready), 1);
      step(0, 1, 5, 4'b0001);
      chk("warm_no_early_gnt", 32'(gnt), 0);
      step(0, 0, 0, 4'b0001);
      chk("warm_gnt", 32'(gnt), 32'b0001);
      chk("warm_rnd", rnd_out, 5);
      step(0, 0, 0, 4'b0000);
      chk("idle_rnd_zero", rnd_out, 0);
      // round robin from a fresh reset
      rst = 1'b1; step(0, 0, 0, 0); rst = 1'b0;
      for (int k = 10; k < 14; k++) step(0, 1, k, 4'b0000);
      step(0, 1, 20, 4'b1111);
      for (int k = 21; k <= 25; k++) begin
         step(0, 1, k, 4'b1111);
         chk("rr_gnt", 32'(gnt), 32'(4'b0001 << ((k - 21) % 4)));
         chk("rr_rnd", rnd_out, k - 1);
      end
      step(0, 0, 0, 4'b1111);
      chk("rr_last_gnt", 32'(gnt), 32'b0010);
      chk("rr_last_rnd", rnd_out, 25);
      // drops: first word kept, nine dropped
      for (int k = 40; k < 50; k++) step(0, 1, k, 4'b0000);
      chk("drop_cnt", 32'(drop_cnt), 9);
      step(0, 0, 0, 4'b0100);
      chk("drop_gnt", 32'(gnt), 32'b0100);
      chk("drop_rnd", rnd_out, 40);
      // starved source: ptr=3, single word goes to requester 0
      for (int k = 0; k < 3; k++) begin
         step(0, 0, 0, 4'b0011);
         chk("starve_gnt", 32'(gnt), 0);
         chk("starve_rnd", rnd_out, 0);
      end
      step(0, 1, 77, 4'b0011);
      step(0, 0, 0, 4'b0011);
      chk("starve_one_gnt", 32'(gnt), 32'b0001);
      chk("starve_one_rnd", rnd_out, 77);
      step(0, 0, 0, 4'b0011);
      chk("starve_no_second", 32'(gnt), 0);
      // flush with full buffer and a pending request
      step(0, 1, 88, 4'b0000);
      step(1, 0, 0, 4'b0010);
      chk("flush_gnt", 32'(gnt), 0);
      chk("flush_ready", 32'(ready), 0);
      for (int k = 90; k < 94; k++) begin
         step(0, 1, k, 4'b0010);
         chk("flush_warm_gnt", 32'(gnt), 0);
      end
      chk("flush_rewarm_ready", 32'(ready), 1);
      step(0, 1, 94, 4'b0010);
      step(0, 0, 0, 4'b0010);
      chk("flush_gnt_after", 32'(gnt), 32'b0010);
      chk("flush_rnd_after", rnd_out, 94);
      chk("flush_drop_kept", 32'(drop_cnt), 9);
      // reset while a winner is being chosen
      step(0, 1, 55, 4'b0001);
      rst = 1'b1;
      step(0, 0, 0, 4'b0001);
      chk("rst_mid_gnt", 32'(gnt), 0);
      chk("rst_mid_rnd", rnd_out, 0);
      chk("rst_mid_vld", 32'(rnd_vld), 0);
      chk("rst_mid_ready", 32'(ready), 0);
      chk("rst_mid_drop", 32'(drop_cnt), 0);
      rst = 1'b0;
      step(0, 0, 0, 4'b0000);
      @(negedge clk); #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
